psk_search_ctl: RTL and testbench
=================================

# psk_search_ctl

Acquisition scheduler for the PSK correlator datapath. Sweeps a grid of NCO frequency (fcw) and phase (pcw) bins, clears the I/Q correlators at the start of each bin and integrates for a fixed window. It then scores each bin by I²+Q² energy and reports the best bin plus a lock flag. It sits between the top-level control and the i/q NCO + correlator pair, driving their control words and clears.

## Interface
Parameters:
- FCW_START, 12'h100, first frequency control word of the sweep
- FCW_STEP, 12'h004, fcw increment between frequency bins
- FCW_COUNT, 16, number of frequency bins (≥1)
- PCW_STEP, 12'h200, pcw increment between phase bins
- PCW_COUNT, 2, number of phase bins per frequency bin (≥1)
- WINDOW, 255, integration length in clk cycles per bin (≥1)
- THRESH, 17'h04000, minimum best energy for lock

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin sweep; sampled only in IDLE
- abort  in  1  cancel sweep; honoured in any non-IDLE state
- i_value  in  8  unsigned I correlator output
- q_value  in  8  unsigned Q correlator output
- fcw_out  out  12  frequency control word to i/q NCOs
- pcw_out  out  12  phase control word to i/q NCOs (Q NCO adds 12'h400 itself)
- corr_rst  out  1  correlator clear, active-high
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at sweep completion
- lock  out  1  best_energy ≥ THRESH at last completion
- best_fcw  out  12  fcw of best bin
- best_pcw  out  12  pcw of best bin
- best_energy  out  17  energy of best bin

## Operation
- States: IDLE, SETTLE, INTEG, SAMPLE, COMPARE, NEXT, FINISH.
- IDLE: start=1 → load fcw_out=FCW_START, pcw_out=0, clear best_* and lock, → SETTLE.
- SETTLE (1 cycle): corr_rst=1; window counter cleared → INTEG.
- INTEG: counter increments each cycle; after WINDOW cycles → SAMPLE.
- SAMPLE (1 cycle): register energy = i_value*i_value + q_value*q_value, 17-bit unsigned, no truncation.
- COMPARE: energy > best_energy (strict) → update best_energy/best_fcw/best_pcw with current bin. Ties keep the earlier bin.
- NEXT: if phase index < PCW_COUNT-1, then pcw_out += PCW_STEP. Else pcw_out=0, and fcw_out += FCW_STEP (12-bit modulo wrap permitted), phase index cleared. After the last bin → FINISH, otherwise → SETTLE.
- FINISH (1 cycle): done=1, lock=(best_energy ≥ THRESH) → IDLE. fcw_out/pcw_out return to best_fcw/best_pcw so the NCOs park on the winner.
- abort: next state IDLE; done not pulsed; lock cleared; best_* hold their partial values; corr_rst not asserted.
- start while busy: ignored. start and abort together in IDLE: start wins. In non-IDLE states abort wins.

## Timing
- Reset values: fcw_out=FCW_START, pcw_out=0, corr_rst=0, busy=0, done=0, lock=0, best_*=0; state IDLE.
- Outputs are registered; corr_rst is high exactly one cycle per bin, in the cycle after entering from IDLE/NEXT.
- Per bin: 1 SETTLE + WINDOW INTEG + SAMPLE + COMPARE + NEXT = WINDOW+4 cycles.
- Sweep: start sampled at edge 0; done high FCW_COUNT*PCW_COUNT*(WINDOW+4)+1 cycles later.
- i_value/q_value are sampled in SAMPLE, i.e. WINDOW cycles after corr_rst falls. The correlator's own output latency must be counted inside WINDOW.
- lock, best_* are stable from the done cycle until the next start.

## Structure
- psk_search_pkg holds: the state enum, CW_W=12, VAL_W=8, EN_W=17.
- One sub-module, psk_energy: registered I²+Q² computation (two 8×8 squares, one 17-bit adder), instantiated once. It is used in SAMPLE.
- Counters: window counter ($clog2(WINDOW+1) bits), phase index, frequency index.

## Test plan
- Reset, then idle for 10 cycles → all outputs at reset values, corr_rst never high.
- Small sweep (FCW_COUNT=3, PCW_COUNT=2, WINDOW=8, FCW_START=12'h100, FCW_STEP=12'h004). Bench model drives i=q=10 for all bins, except i=200, q=50 at fcw=12'h104, pcw=12'h200. Required: done after 6*12+1 cycles, best_fcw=12'h104, best_pcw=12'h200, best_energy=42500, lock=1.
- Equal energies in every bin → best_fcw=12'h100, best_pcw=0 (first bin kept). With THRESH above 200 → lock=0.
- Assert abort during INTEG of bin 2 → busy falls next cycle, no done pulse, lock=0. A new start then runs a full sweep correctly.
- start pulsed mid-sweep → ignored; corr_rst count over the sweep equals FCW_COUNT*PCW_COUNT exactly.
- FCW_START=12'hFFC, FCW_STEP=12'h004, FCW_COUNT=2 → second bin uses fcw 12'h000 (modulo wrap).

Source files
------------

// File: rtl/psk_search_pkg.sv
// Shared types and widths for the PSK acquisition scheduler.
package psk_search_pkg;

    localparam int CW_W  = 12;
    localparam int VAL_W = 8;
    localparam int EN_W  = 17;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        INTEG,
        SAMPLE,
        COMPARE,
        NEXT,
        FINISH
    } state_t;

endpackage

// File: rtl/psk_search_ctl_if.sv
// Control, correlator and result signals of the acquisition scheduler.
interface psk_search_ctl_if;
    import psk_search_pkg::*;

    logic             start;
    logic             abort;
    logic [VAL_W-1:0] i_value;
    logic [VAL_W-1:0] q_value;
    logic [CW_W-1:0]  fcw_out;
    logic [CW_W-1:0]  pcw_out;
    logic             corr_rst;
    logic             busy;
    logic             done;
    logic             lock;
    logic [CW_W-1:0]  best_fcw;
    logic [CW_W-1:0]  best_pcw;
    logic [EN_W-1:0]  best_energy;

    modport master (
        output start, abort, i_value, q_value,
        input  fcw_out, pcw_out, corr_rst, busy, done, lock,
               best_fcw, best_pcw, best_energy
    );

    modport slave (
        input  start, abort, i_value, q_value,
        output fcw_out, pcw_out, corr_rst, busy, done, lock,
               best_fcw, best_pcw, best_energy
    );

endinterface

// File: rtl/psk_energy.sv
// Registered I^2 + Q^2 energy of the correlator outputs, captured when en is high.
module psk_energy
    import psk_search_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [VAL_W-1:0] i_value,
    input  logic [VAL_W-1:0] q_value,
    output logic [EN_W-1:0]  energy
);

    logic [2*VAL_W-1:0] i_sq;
    logic [2*VAL_W-1:0] q_sq;

    assign i_sq = {{VAL_W{1'b0}}, i_value} * {{VAL_W{1'b0}}, i_value};
    assign q_sq = {{VAL_W{1'b0}}, q_value} * {{VAL_W{1'b0}}, q_value};

    // Squares are widened by one bit before the add so the sum never truncates.
    always_ff @(posedge clk) begin
        if (rst) begin
            energy <= '0;
        end else if (en) begin
            energy <= {1'b0, i_sq} + {1'b0, q_sq};
        end
    end

endmodule

// File: rtl/psk_search_ctl.sv
// Sweeps the fcw/pcw bin grid, integrates each bin, and reports the highest-energy bin.
module psk_search_ctl
    import psk_search_pkg::*;
#(
    parameter logic [CW_W-1:0] FCW_START = 12'h100,
    parameter logic [CW_W-1:0] FCW_STEP  = 12'h004,
    parameter int              FCW_COUNT = 16,
    parameter logic [CW_W-1:0] PCW_STEP  = 12'h200,
    parameter int              PCW_COUNT = 2,
    parameter int              WINDOW    = 255,
    parameter logic [EN_W-1:0] THRESH    = 17'h04000
)
(
    input logic             clk,
    input logic             rst,
    psk_search_ctl_if.slave bus
);

    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam int PH_W  = $clog2(PCW_COUNT + 1);
    localparam int FR_W  = $clog2(FCW_COUNT + 1);

    state_t           state;
    logic [CNT_W-1:0] win_cnt;
    logic [PH_W-1:0]  phase_idx;
    logic [FR_W-1:0]  freq_idx;
    logic [EN_W-1:0]  energy;

    psk_energy u_energy (
        .clk     (clk),
        .rst     (rst),
        .en      (state == SAMPLE),
        .i_value (bus.i_value),
        .q_value (bus.q_value),
        .energy  (energy)
    );

    // corr_rst is raised on every transition into SETTLE, so it spans exactly the SETTLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            win_cnt         <= '0;
            phase_idx       <= '0;
            freq_idx        <= '0;
            bus.fcw_out     <= FCW_START;
            bus.pcw_out     <= '0;
            bus.corr_rst    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.lock        <= 1'b0;
            bus.best_fcw    <= '0;
            bus.best_pcw    <= '0;
            bus.best_energy <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.corr_rst <= 1'b0;
            if (state != IDLE && bus.abort) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
                bus.lock <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            bus.fcw_out     <= FCW_START;
                            bus.pcw_out     <= '0;
                            bus.best_fcw    <= '0;
                            bus.best_pcw    <= '0;
                            bus.best_energy <= '0;
                            bus.lock        <= 1'b0;
                            phase_idx       <= '0;
                            freq_idx        <= '0;
                            bus.corr_rst    <= 1'b1;
                            bus.busy        <= 1'b1;
                            state           <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        win_cnt <= '0;
                        state   <= INTEG;
                    end
                    INTEG: begin
                        if (win_cnt == CNT_W'(WINDOW - 1)) begin
                            state <= SAMPLE;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                        end
                    end
                    SAMPLE: begin
                        state <= COMPARE;
                    end
                    COMPARE: begin
                        if (energy > bus.best_energy) begin
                            bus.best_energy <= energy;
                            bus.best_fcw    <= bus.fcw_out;
                            bus.best_pcw    <= bus.pcw_out;
                        end
                        state <= NEXT;
                    end
                    NEXT: begin
                        if (phase_idx < PH_W'(PCW_COUNT - 1)) begin
                            bus.pcw_out  <= bus.pcw_out + PCW_STEP;
                            phase_idx    <= phase_idx + 1'b1;
                            bus.corr_rst <= 1'b1;
                            state        <= SETTLE;
                        end else begin
                            bus.pcw_out <= '0;
                            bus.fcw_out <= bus.fcw_out + FCW_STEP;
                            phase_idx   <= '0;
                            if (freq_idx == FR_W'(FCW_COUNT - 1)) begin
                                state <= FINISH;
                            end else begin
                                freq_idx     <= freq_idx + 1'b1;
                                bus.corr_rst <= 1'b1;
                                state        <= SETTLE;
                            end
                        end
                    end
                    FINISH: begin
                        bus.done    <= 1'b1;
                        bus.lock    <= (bus.best_energy >= THRESH);
                        bus.fcw_out <= bus.best_fcw;
                        bus.pcw_out <= bus.best_pcw;
                        bus.busy    <= 1'b0;
                        state       <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psk_search_ctl.sv
// Self-checking bench: correlator stand-in keyed on fcw/pcw, best-bin model computed from the bin table.
module tb_psk_search_ctl;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    int   crst_a = 0;
    int   done_a = 0;

    always #5 clk = ~clk;

    psk_search_ctl_if ifa ();
    psk_search_ctl_if ifb ();

    psk_search_ctl #(
        .FCW_START (12'h100), .FCW_STEP (12'h004), .FCW_COUNT (3),
        .PCW_STEP  (12'h200), .PCW_COUNT (2), .WINDOW (8), .THRESH (17'h04000)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    psk_search_ctl #(
        .FCW_START (12'hFFC), .FCW_STEP (12'h004), .FCW_COUNT (2),
        .PCW_STEP  (12'h200), .PCW_COUNT (1), .WINDOW (4), .THRESH (17'h04000)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    logic [7:0] vi [0:5];
    logic [7:0] vq [0:5];
    logic [7:0] vib [0:1];
    logic [7:0] vqb [0:1];
    logic [7:0] ia, qa, ib, qb;

    // Bin b of the small sweep sits at frequency b/2, phase b%2.
    function automatic logic [11:0] a_fcw(int b);
        return 12'((32'h100 + (b / 2) * 4) % 4096);
    endfunction

    function automatic logic [11:0] a_pcw(int b);
        return 12'(((b % 2) * 32'h200) % 4096);
    endfunction

    function automatic logic [11:0] b_fcw(int b);
        return 12'((32'hFFC + b * 4) % 4096);
    endfunction

    always_comb begin
        ia = 8'd0;
        qa = 8'd0;
        for (int b = 0; b < 6; b++) begin
            if (ifa.fcw_out == a_fcw(b) && ifa.pcw_out == a_pcw(b)) begin
                ia = vi[b];
                qa = vq[b];
            end
        end
        ib = 8'd0;
        qb = 8'd0;
        for (int b = 0; b < 2; b++) begin
            if (ifb.fcw_out == b_fcw(b) && ifb.pcw_out == 12'h000) begin
                ib = vib[b];
                qb = vqb[b];
            end
        end
    end

    assign ifa.i_value = ia;
    assign ifa.q_value = qa;
    assign ifb.i_value = ib;
    assign ifb.q_value = qb;

    always @(posedge clk) begin
        if (ifa.corr_rst === 1'b1) crst_a <= crst_a + 1;
        if (ifa.done === 1'b1)     done_a <= done_a + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_a(output logic [11:0] ef, output logic [11:0] ep, output logic [16:0] ee);
        int best = 0;
        ef = 12'h000;
        ep = 12'h000;
        for (int b = 0; b < 6; b++) begin
            int e = int'(vi[b]) * int'(vi[b]) + int'(vq[b]) * int'(vq[b]);
            if (e > best) begin
                best = e;
                ef   = a_fcw(b);
                ep   = a_pcw(b);
            end
        end
        ee = 17'(best);
    endtask

    task automatic apply_stimulus(input int mode);
        for (int b = 0; b < 6; b++) begin
            if (mode == 0) begin
                vi[b] = 8'd10;
                vq[b] = 8'd10;
            end else begin
                vi[b] = 8'($urandom_range(0, 255));
                vq[b] = 8'($urandom_range(0, 255));
            end
        end
    endtask

    task automatic run_sweep_a(input string tag, input bit mid_start);
        int cyc = 0;
        int c0;
        logic [11:0] ef, ep;
        logic [16:0] ee;
        c0 = crst_a;
        ifa.start = 1'b1;
        tick;
        ifa.start = 1'b0;
        while (ifa.done !== 1'b1 && cyc < 500) begin
            ifa.start = (mid_start && cyc == 30);
            tick;
            cyc++;
        end
        ifa.start = 1'b0;
        model_a(ef, ep, ee);
        $display("[TB] %s: latency %0d cycles", tag, cyc);
        check_output({tag, ".latency"},     cyc, 73);
        check_output({tag, ".best_fcw"},    ifa.best_fcw, ef);
        check_output({tag, ".best_pcw"},    ifa.best_pcw, ep);
        check_output({tag, ".best_energy"}, ifa.best_energy, ee);
        check_output({tag, ".lock"},        ifa.lock, (ee >= 17'h04000));
        check_output({tag, ".busy"},        ifa.busy, 0);
        check_output({tag, ".park_fcw"},    ifa.fcw_out, ef);
        check_output({tag, ".park_pcw"},    ifa.pcw_out, ep);
        check_output({tag, ".corr_rst_cnt"}, crst_a - c0, 6);
        tick;
        check_output({tag, ".done_pulse"},  ifa.done, 0);
        check_output({tag, ".lock_hold"},   ifa.lock, (ee >= 17'h04000));
    endtask

    initial begin
        int c0, d0, cyc, e0;
        rst = 1'b1;
        ifa.start = 1'b0;
        ifa.abort = 1'b0;
        ifb.start = 1'b0;
        ifb.abort = 1'b0;
        apply_stimulus(0);
        vib[0] = 8'd10;
        vqb[0] = 8'd10;
        vib[1] = 8'd150;
        vqb[1] = 8'd150;
        repeat (3) tick;
        rst = 1'b0;
        c0 = crst_a;
        repeat (10) tick;

        check_output("rst.fcw_out",     ifa.fcw_out, 12'h100);
        check_output("rst.pcw_out",     ifa.pcw_out, 0);
        check_output("rst.corr_rst",    ifa.corr_rst, 0);
        check_output("rst.busy",        ifa.busy, 0);
        check_output("rst.done",        ifa.done, 0);
        check_output("rst.lock",        ifa.lock, 0);
        check_output("rst.best_fcw",    ifa.best_fcw, 0);
        check_output("rst.best_pcw",    ifa.best_pcw, 0);
        check_output("rst.best_energy", ifa.best_energy, 0);
        check_output("rst.corr_rst_cnt", crst_a - c0, 0);
        check_output("rst.b_fcw_out",   ifb.fcw_out, 12'hFFC);

        // One strong bin at fcw 0x104 / pcw 0x200 (bin 3).
        apply_stimulus(0);
        vi[3] = 8'd200;
        vq[3] = 8'd50;
        run_sweep_a("strong_bin", 1'b0);
        check_output("strong_bin.exact_energy", ifa.best_energy, 42500);

        apply_stimulus(0);
        run_sweep_a("equal", 1'b0);

        for (int r = 0; r < 3; r++) begin
            apply_stimulus(1);
            run_sweep_a("random", 1'b0);
        end

        // Abort during the second bin's integration.
        apply_stimulus(1);
        e0 = int'(vi[0]) * int'(vi[0]) + int'(vq[0]) * int'(vq[0]);
        d0 = done_a;
        ifa.start = 1'b1;
        tick;
        ifa.start = 1'b0;
        repeat (15) tick;
        check_output("abort.busy_before", ifa.busy, 1);
        ifa.abort = 1'b1;
        tick;
        ifa.abort = 1'b0;
        check_output("abort.busy", ifa.busy, 0);
        check_output("abort.lock", ifa.lock, 0);
        check_output("abort.corr_rst", ifa.corr_rst, 0);
        check_output("abort.partial_energy", ifa.best_energy, e0);
        check_output("abort.partial_fcw", ifa.best_fcw, (e0 > 0) ? 12'h100 : 12'h000);
        repeat (30) tick;
        check_output("abort.no_done", done_a - d0, 0);
        check_output("abort.still_idle", ifa.busy, 0);
        apply_stimulus(1);
        run_sweep_a("after_abort", 1'b0);

        apply_stimulus(1);
        run_sweep_a("mid_start", 1'b1);

        // Frequency wrap: second bin of dut_b lands on fcw 0x000.
        ifb.start = 1'b1;
        tick;
        ifb.start = 1'b0;
        cyc = 0;
        while (ifb.done !== 1'b1 && cyc < 200) begin
            tick;
            cyc++;
        end
        check_output("wrap.latency",     cyc, 17);
        check_output("wrap.best_fcw",    ifb.best_fcw, b_fcw(1));
        check_output("wrap.best_pcw",    ifb.best_pcw, 0);
        check_output("wrap.best_energy", ifb.best_energy, 45000);
        check_output("wrap.lock",        ifb.lock, 1);
        check_output("wrap.park_fcw",    ifb.fcw_out, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
